pwm_ramp_sequencer: RTL and testbench
=====================================

# pwm_ramp_sequencer

Bus-master sequencer that drives the PWM peripheral's register port to ramp the duty cycle from its current value to a target value in programmable steps at a programmable interval (soft-start / soft-stop). It sits between the system control logic and the PWM register interface, issues config writes to address 0x00 and status reads from address 0x04 after each step, and stops with an error if the peripheral flags one.

## Interface
- AW, 8: register address width
- DW, 32: register data width
- WIDTH_PERIOD, 16: period field width, bits [31:16] of the config word
- WIDTH_DUTY, 16: duty field width, bits [15:0] of the config word
- WIDTH_TICK, 16: interval counter width

- clk_i  in  1  single clock; all logic is rising-edge
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle start pulse; honoured only in IDLE
- abort_i  in  1  level; forces IDLE
- period_i  in  WIDTH_PERIOD  period to program; latched on an accepted start
- target_duty_i  in  WIDTH_DUTY  final duty; latched on start
- step_i  in  WIDTH_DUTY  duty increment per step; latched on start; 0 = jump directly to target
- interval_i  in  WIDTH_TICK  wait cycles between steps; latched on start; 0 treated as 1
- busy_o  out  1  high from the cycle after an accepted start until return to IDLE
- done_o  out  1  one-cycle pulse at completion, on success or error
- err_o  out  1  sticky error; cleared on the next accepted start
- cur_duty_o  out  WIDTH_DUTY  last duty value actually written
- pwm_addr_o  out  AW  register address
- pwm_wr_data_o  out  DW  write data, {period, duty}
- pwm_wr_en_o  out  1  one-cycle write strobe
- pwm_rd_en_o  out  1  one-cycle read strobe
- pwm_rd_data_i  in  DW  read data; valid the cycle after pwm_rd_en_o

## Operation
- States: IDLE, CHECK, WRITE, READ, SAMPLE, WAIT, DONE.
- IDLE: start_i latches the inputs and moves to CHECK. err_o clears.
- CHECK:
  - target > period: set err_o and go to DONE. No bus access.
  - Otherwise compute next_duty and go to WRITE.
- next_duty rule (17-bit arithmetic, no wrap):
  - cur < target: next = min(cur + step, target).
  - cur > target: next = max(cur − step, target), computed as target if (cur − target) ≤ step.
  - step = 0: next = target.
  - cur = target: one write of target is still issued.
- WRITE: assert pwm_addr_o = 0x00, pwm_wr_data_o = {period, next_duty}, pwm_wr_en_o = 1 for one cycle. cur_duty_o ← next_duty. Then go to READ.
- READ: assert pwm_addr_o = 0x04 and pwm_rd_en_o = 1 for one cycle. Then go to SAMPLE.
- SAMPLE: capture pwm_rd_data_i.
  - Bit 0 = 1 (peripheral error flag): set err_o and go to DONE.
  - Else if cur_duty = target: go to DONE.
  - Else: load the tick counter with max(interval, 1) and go to WAIT.
- WAIT: decrement the counter. At 1, compute next_duty and go to WRITE.
- DONE: pulse done_o, then go to IDLE.
- abort_i high in any non-IDLE state:
  - Next state is IDLE and all strobes are 0 from the next edge.
  - No done_o pulse; err_o unchanged; cur_duty_o holds.
- start_i while busy is ignored. start_i and abort_i together in IDLE: abort wins, start is dropped.
- cur_duty_o persists across runs, so the next ramp starts from the last written duty.

## Timing
- All outputs are registered.
- Reset values:
  - State IDLE.
  - busy_o, done_o, err_o, pwm_wr_en_o, pwm_rd_en_o all 0.
  - cur_duty_o, pwm_addr_o, pwm_wr_data_o all 0.
- Start accepted at edge N:
  - CHECK at N+1.
  - First pwm_wr_en_o visible in cycle N+2.
  - pwm_rd_en_o in cycle N+3.
  - Sample in cycle N+4.
- Write-to-write spacing = 3 + max(interval, 1) cycles.
- done_o is asserted the cycle after the final SAMPLE (or the cycle after CHECK on a range error). busy_o falls together with done_o.
- Strobes are never asserted simultaneously. pwm_addr_o is stable during each strobe.
- Reset mid-ramp: immediate return to the reset values. The PWM peripheral keeps its last written config.

## Test plan
- Ramp up: cur 0, period 1000, target 250, step 100, interval 4 -> writes {1000,100}, {1000,200}, {1000,250}, each 7 cycles apart. Reads at 0x04 follow each write; one done_o; err_o = 0.
- Ramp down: then target 50, step 100 -> writes duty 150, then 50; cur_duty_o = 50.
- Range error: period 400, target 700 -> no pwm_wr_en_o or pwm_rd_en_o. err_o = 1 and done_o 2 cycles after start.
- Status error: pwm_rd_data_i bit 0 forced to 1 after the first write -> exactly one write; err_o = 1; done_o pulses.
- Abort and busy start: abort_i during WAIT of the second step -> IDLE, no further strobes, no done_o, cur_duty_o = 200. A start_i during an active ramp has no effect.
- Step 0 and reset: step 0 -> exactly one write of target. Reset asserted during WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/pwm_ramp_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pwm_ramp_sequencer
// Purpose  : Bus master that ramps the PWM peripheral duty cycle toward a
//            target in programmable steps, writing the config register and
//            reading back status after every step.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_ramp_sequencer #(
    parameter int AW           = 8,
    parameter int DW           = 32,
    parameter int WIDTH_PERIOD = 16,
    parameter int WIDTH_DUTY   = 16,
    parameter int WIDTH_TICK   = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic [WIDTH_PERIOD-1:0] period_i,
    input  logic [WIDTH_DUTY-1:0]   target_duty_i,
    input  logic [WIDTH_DUTY-1:0]   step_i,
    input  logic [WIDTH_TICK-1:0]   interval_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic [WIDTH_DUTY-1:0]   cur_duty_o,
    output logic [AW-1:0]           pwm_addr_o,
    output logic [DW-1:0]           pwm_wr_data_o,
    output logic                    pwm_wr_en_o,
    output logic                    pwm_rd_en_o,
    input  logic [DW-1:0]           pwm_rd_data_i
);

    localparam logic [AW-1:0] ADDR_CFG    = AW'(0);
    localparam logic [AW-1:0] ADDR_STATUS = AW'(4);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_WRITE  = 3'd2,
        S_READ   = 3'd3,
        S_SAMPLE = 3'd4,
        S_WAIT   = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    set_err;
    logic                    start_accept;
    logic [WIDTH_PERIOD-1:0] period_q;
    logic [WIDTH_DUTY-1:0]   target_q;
    logic [WIDTH_DUTY-1:0]   step_q;
    logic [WIDTH_TICK-1:0]   interval_q;
    logic [WIDTH_TICK-1:0]   tick_cnt;
    logic [WIDTH_TICK-1:0]   tick_load;
    logic [WIDTH_DUTY-1:0]   next_duty;
    logic [WIDTH_DUTY:0]     sum_ext;
    logic [WIDTH_DUTY:0]     diff_ext;
    logic                    unused_rd_bits;

    // Only the error flag of the status word matters here.
    assign unused_rd_bits = ^pwm_rd_data_i[DW-1:1];

    assign start_accept = (state == S_IDLE) && start_i && !abort_i;
    // An interval of zero behaves like one wait cycle.
    assign tick_load    = (interval_q == '0) ? WIDTH_TICK'(1) : interval_q;

    // Next duty: one step toward the target, clamped so it never overshoots.
    always_comb begin
        sum_ext  = {1'b0, cur_duty_o} + {1'b0, step_q};
        diff_ext = {1'b0, cur_duty_o} - {1'b0, target_q};
        next_duty = target_q;
        if (step_q == '0 || cur_duty_o == target_q) begin
            next_duty = target_q;
        end else if (cur_duty_o < target_q) begin
            next_duty = (sum_ext >= {1'b0, target_q}) ? target_q : sum_ext[WIDTH_DUTY-1:0];
        end else begin
            next_duty = (diff_ext <= {1'b0, step_q}) ? target_q : (cur_duty_o - step_q);
        end
    end

    // Next-state logic; abort overrides every non-idle transition.
    always_comb begin
        state_next = state;
        set_err    = 1'b0;
        case (state)
            S_IDLE:   if (start_accept) state_next = S_CHECK;
            S_CHECK: begin
                if (32'(target_q) > 32'(period_q)) begin
                    set_err    = 1'b1;
                    state_next = S_DONE;
                end else begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE:  state_next = S_READ;
            S_READ:   state_next = S_SAMPLE;
            S_SAMPLE: begin
                if (pwm_rd_data_i[0]) begin
                    set_err    = 1'b1;
                    state_next = S_DONE;
                end else if (cur_duty_o == target_q) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT:   if (tick_cnt <= WIDTH_TICK'(1)) state_next = S_WRITE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
        if (state != S_IDLE && abort_i) begin
            state_next = S_IDLE;
            set_err    = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= S_IDLE;
        else         state <= state_next;
    end

    // Ramp parameters captured on an accepted start, plus the interval counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            period_q   <= '0;
            target_q   <= '0;
            step_q     <= '0;
            interval_q <= '0;
            tick_cnt   <= '0;
        end else begin
            if (start_accept) begin
                period_q   <= period_i;
                target_q   <= target_duty_i;
                step_q     <= step_i;
                interval_q <= interval_i;
            end
            if (state == S_SAMPLE && state_next == S_WAIT) tick_cnt <= tick_load;
            else if (state == S_WAIT)                      tick_cnt <= tick_cnt - WIDTH_TICK'(1);
        end
    end

    // Registered outputs decoded from the state being entered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
            cur_duty_o    <= '0;
            pwm_addr_o    <= '0;
            pwm_wr_data_o <= '0;
            pwm_wr_en_o   <= 1'b0;
            pwm_rd_en_o   <= 1'b0;
        end else begin
            busy_o      <= (state_next != S_IDLE);
            done_o      <= (state_next == S_DONE);
            pwm_wr_en_o <= (state_next == S_WRITE);
            pwm_rd_en_o <= (state_next == S_READ);
            if (start_accept)  err_o <= 1'b0;
            else if (set_err)  err_o <= 1'b1;
            if (state_next == S_WRITE) begin
                pwm_addr_o    <= ADDR_CFG;
                pwm_wr_data_o <= DW'({period_q, next_duty});
                cur_duty_o    <= next_duty;
            end else if (state_next == S_READ) begin
                pwm_addr_o    <= ADDR_STATUS;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_ramp_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_ramp_sequencer
// Purpose  : Scoreboard bench for pwm_ramp_sequencer; directed ramps with
//            hand-computed bus transactions and completion status.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_ramp_sequencer;

    localparam logic [2:0] C_WR = 3'b001;
    localparam logic [2:0] C_RD = 3'b010;
    localparam logic [2:0] C_DN = 3'b100;

    typedef struct {
        logic [2:0]  code;
        logic [7:0]  addr;
        logic [31:0] data;
        int          gap;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [15:0] period_i = '0;
    logic [15:0] target_duty_i = '0;
    logic [15:0] step_i = '0;
    logic [15:0] interval_i = '0;
    logic        busy_o, done_o, err_o;
    logic [15:0] cur_duty_o;
    logic [7:0]  pwm_addr_o;
    logic [31:0] pwm_wr_data_o;
    logic        pwm_wr_en_o, pwm_rd_en_o;
    logic [31:0] pwm_rd_data_i = 32'hFFFF_FFFE;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [2:0]  mon_code;
    int          cyc = 0;
    int          ref_cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          acc;

    pwm_ramp_sequencer dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .period_i      (period_i),
        .target_duty_i (target_duty_i),
        .step_i        (step_i),
        .interval_i    (interval_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .cur_duty_o    (cur_duty_o),
        .pwm_addr_o    (pwm_addr_o),
        .pwm_wr_data_o (pwm_wr_data_o),
        .pwm_wr_en_o   (pwm_wr_en_o),
        .pwm_rd_en_o   (pwm_rd_en_o),
        .pwm_rd_data_i (pwm_rd_data_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_w(input int duty, input int gap);
        sb.push_back('{code: C_WR, addr: 8'h00, data: {16'd1000, 16'(duty)}, gap: gap});
    endtask

    task automatic push_r(input int gap);
        sb.push_back('{code: C_RD, addr: 8'h04, data: 32'h0, gap: gap});
    endtask

    task automatic push_d(input logic err, input int duty, input int gap);
        sb.push_back('{code: C_DN, addr: 8'h00, data: {15'b0, err, 16'(duty)}, gap: gap});
    endtask

    task automatic start_ramp(input int p, input int t, input int s, input int iv, output int acc_cyc);
        @(negedge clk);
        period_i      = 16'(p);
        target_duty_i = 16'(t);
        step_i        = 16'(s);
        interval_i    = 16'(iv);
        start_i       = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        ref_cyc = cyc;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_empty(input int budget);
        int k;
        k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain_timeout: pending=%0d expected=0", sb.size());
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // Monitor: every strobe or done pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_ni && (pwm_wr_en_o || pwm_rd_en_o || done_o)) begin
            mon_code = {done_o, pwm_rd_en_o, pwm_wr_en_o};
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event: actual code=%b expected none (cycle %0d)", mon_code, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("event_kind", 32'(mon_code), 32'(mon_e.code));
                check("event_gap", 32'(cyc - ref_cyc), 32'(mon_e.gap));
                if (mon_e.code == C_WR) begin
                    check("wr_addr", 32'(pwm_addr_o), 32'(mon_e.addr));
                    check("wr_data", pwm_wr_data_o, mon_e.data);
                end else if (mon_e.code == C_RD) begin
                    check("rd_addr", 32'(pwm_addr_o), 32'(mon_e.addr));
                end else begin
                    check("done_err_duty", {15'b0, err_o, cur_duty_o}, mon_e.data);
                    check("busy_at_done", 32'(busy_o), 32'd1);
                end
            end
            ref_cyc = cyc;
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_wr_en", 32'(pwm_wr_en_o), 32'd0);
        check("rst_rd_en", 32'(pwm_rd_en_o), 32'd0);
        check("rst_cur_duty", 32'(cur_duty_o), 32'd0);
        check("rst_addr", 32'(pwm_addr_o), 32'd0);
        check("rst_wr_data", pwm_wr_data_o, 32'd0);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk);

        // Ramp up 0 -> 250 in steps of 100, writes 7 cycles apart.
        push_w(100, 1); push_r(1);
        push_w(200, 6); push_r(1);
        push_w(250, 6); push_r(1);
        push_d(1'b0, 250, 2);
        start_ramp(1000, 250, 100, 4, acc);
        wait_empty(100);

        // Ramp down 250 -> 50, interval 0 acts as 1.
        push_w(150, 1); push_r(1);
        push_w(50, 3);  push_r(1);
        push_d(1'b0, 50, 2);
        start_ramp(1000, 50, 100, 0, acc);
        wait_empty(100);
        check("down_cur_duty", 32'(cur_duty_o), 32'd50);

        // Target above period: no bus access, error and done one cycle after CHECK.
        push_d(1'b1, 50, 1);
        start_ramp(400, 700, 10, 1, acc);
        wait_empty(50);
        check("range_busy_after", 32'(busy_o), 32'd0);

        // Peripheral reports an error after the first write.
        pwm_rd_data_i = 32'h0000_0001;
        push_w(150, 1); push_r(1);
        push_d(1'b1, 150, 2);
        start_ramp(1000, 500, 100, 2, acc);
        wait_empty(50);
        pwm_rd_data_i = 32'hFFFF_FFFE;
        check("stat_err_sticky", 32'(err_o), 32'd1);

        // Abort during the second wait; a start while busy is ignored.
        push_w(175, 1); push_r(1);
        push_w(200, 7); push_r(1);
        start_ramp(1000, 350, 25, 5, acc);
        while (cyc < acc + 3) @(negedge clk);
        target_duty_i = 16'd0;
        step_i        = 16'd1;
        interval_i    = 16'd1;
        start_i       = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        while (cyc < acc + 13) @(negedge clk);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_pending", 32'(sb.size()), 32'd0);
        sb.delete();
        check("abort_cur_duty", 32'(cur_duty_o), 32'd200);
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_err", 32'(err_o), 32'd0);

        // Step 0 jumps straight to the target with one write.
        push_w(600, 1); push_r(1);
        push_d(1'b0, 600, 2);
        start_ramp(1000, 600, 0, 3, acc);
        wait_empty(50);

        // Reset while waiting between steps.
        push_w(500, 1); push_r(1);
        start_ramp(1000, 100, 100, 8, acc);
        while (cyc < acc + 6) @(negedge clk);
        rst_ni = 1'b0;
        #1;
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_cur_duty", 32'(cur_duty_o), 32'd0);
        check("midrst_wr_data", pwm_wr_data_o, 32'd0);
        check("midrst_addr", 32'(pwm_addr_o), 32'd0);
        check("midrst_pending", 32'(sb.size()), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_busy", 32'(busy_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
